// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multicycle RV32I datapath (shared memory, one ALU,
//   architectural registers PC, OldPC, IR, Data, ALUOut). Each instruction
//   goes through Fetch/Decode/Execute/Writeback states. The FSM drives every
//   mux select and write enable, and it stalls on the memory ready handshake.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   op_i               IR[6:0] opcode (IR is stable after FETCH)
//   zero_i             ALU zero flag (BEQ decision)
//   mem_ready_i        memory completes the current request this cycle
//   mem_req_o          memory access request
//   mem_write_o        memory write strobe
//   adr_src_o          memory address: 0=PC, 1=ALUOut
//   ir_write_o         load IR and OldPC
//   pc_write_o         load PC
//   reg_write_o        register file write
//   alu_src_a_o        ALU A: 00=PC, 01=OldPC, 10=rs1
//   alu_src_b_o        ALU B: 00=rs2, 01=imm, 10=constant 4
//   alu_op_o           00=add, 01=sub, 10=funct-decoded
//   result_src_o       00=ALUOut, 01=Data, 10=ALU result
//   imm_src_o          immediate format, decoded from op_i
//   state_o            current state (debug / verification)
//   instr_done_o       pulse in the final cycle of each instruction
//   illegal_o          pulse when DECODE sees an unsupported opcode
//
// Memory handshake: mem_req_o is held high, with a stable adr_src_o, until a
// cycle in which mem_ready_i=1. That cycle completes the transfer. Strobes
// that commit the transfer (ir_write, pc_write in FETCH, mem_write) assert
// only in that cycle. No request is pending unless mem_req_o=1.
// ---------------------------------------------------------------------------
module multicycle_controller (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] op_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       mem_write_o,
   output logic       adr_src_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       reg_write_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o,
   output logic [1:0] result_src_o,
   output logic [1:0] imm_src_o,
   output logic [3:0] state_o,
   output logic       instr_done_o,
   output logic       illegal_o
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECR    = 4'd6;
   localparam logic [3:0] EXECI    = 4'd7;
   localparam logic [3:0] ALUWB    = 4'd8;
   localparam logic [3:0] BEQ      = 4'd9;
   localparam logic [3:0] JAL      = 4'd10;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   logic [3:0] state;
   logic [3:0] state_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= FETCH;
      else       state <= state_next;
   end

   assign state_o = state;

   always_comb begin
      state_next   = FETCH;
      mem_req_o    = 1'b0;
      mem_write_o  = 1'b0;
      adr_src_o    = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      result_src_o = 2'b00;
      instr_done_o = 1'b0;
      illegal_o    = 1'b0;
      case (state)
         FETCH: begin
            // ALU computes PC+4 while the instruction is read.
            mem_req_o    = 1'b1;
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
            ir_write_o   = mem_ready_i;
            pc_write_o   = mem_ready_i;
            state_next   = mem_ready_i ? DECODE : FETCH;
         end
         DECODE: begin
            // OldPC + imm: branch target lands in ALUOut for BEQ.
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            case (op_i)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECR;
               OP_I:         state_next = EXECI;
               OP_BEQ:       state_next = BEQ;
               OP_JAL:       state_next = JAL;
               default: begin
                  illegal_o    = 1'b1;
                  instr_done_o = 1'b1;
                  state_next   = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            state_next  = (op_i == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            mem_req_o  = 1'b1;
            adr_src_o  = 1'b1;
            state_next = mem_ready_i ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_src_o = 2'b01;
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
         end
         MEMWRITE: begin
            mem_req_o    = 1'b1;
            adr_src_o    = 1'b1;
            mem_write_o  = mem_ready_i;
            instr_done_o = mem_ready_i;
            state_next   = mem_ready_i ? FETCH : MEMWRITE;
         end
         EXECR: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b10;
            state_next  = ALUWB;
         end
         EXECI: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            alu_op_o    = 2'b10;
            state_next  = ALUWB;
         end
         ALUWB: begin
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
         end
         BEQ: begin
            // PC takes the target already held in ALUOut when rs1 == rs2.
            alu_src_a_o  = 2'b10;
            alu_op_o     = 2'b01;
            pc_write_o   = zero_i;
            instr_done_o = 1'b1;
         end
         JAL: begin
            // PC <= ALUOut (target); ALU forms OldPC+4 for the link register.
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            pc_write_o  = 1'b1;
            state_next  = ALUWB;
         end
         default: state_next = FETCH;
      endcase

      // Reset kills every side effect, including the cycle that aborts an
      // instruction in flight.
      if (rst_i) begin
         mem_req_o    = 1'b0;
         mem_write_o  = 1'b0;
         ir_write_o   = 1'b0;
         pc_write_o   = 1'b0;
         reg_write_o  = 1'b0;
         instr_done_o = 1'b0;
         illegal_o    = 1'b0;
      end
   end

   always_comb begin
      case (op_i)
         OP_SW:   imm_src_o = 2'b01;
         OP_BEQ:  imm_src_o = 2'b10;
         OP_JAL:  imm_src_o = 2'b11;
         default: imm_src_o = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//   Self-checking bench for multicycle_controller. Each instruction is
//   expanded by a small reference model into a per-cycle list of
//   (mem_ready to drive, expected {state, strobes}). The lists are pushed to
//   queues, then replayed cycle by cycle and compared at the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [6:0] op_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o;
   logic       reg_write_o, instr_done_o, illegal_o;
   logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o;
   logic [3:0] state_o;

   multicycle_controller dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .op_i         (op_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_write_o  (mem_write_o),
      .adr_src_o    (adr_src_o),
      .ir_write_o   (ir_write_o),
      .pc_write_o   (pc_write_o),
      .reg_write_o  (reg_write_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .result_src_o (result_src_o),
      .imm_src_o    (imm_src_o),
      .state_o      (state_o),
      .instr_done_o (instr_done_o),
      .illegal_o    (illegal_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard ----------------
   // Strobe field order: mem_req, mem_write, ir_write, pc_write,
   //                     reg_write, instr_done, illegal
   logic [10:0] exp_q[$];
   logic        rdy_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [10:0] observed();
      return {state_o, mem_req_o, mem_write_o, ir_write_o, pc_write_o,
              reg_write_o, instr_done_o, illegal_o};
   endfunction

   // {adr_src, alu_src_a, alu_src_b, alu_op, result_src} expected per state
   function automatic logic [8:0] mux_ref(input logic [3:0] st);
      case (st)
         4'd0:    return {1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
         4'd1:    return {1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
         4'd2:    return {1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
         4'd3:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
         4'd4:    return {1'b0, 2'b00, 2'b00, 2'b00, 2'b01};
         4'd5:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
         4'd6:    return {1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
         4'd7:    return {1'b0, 2'b10, 2'b01, 2'b10, 2'b00};
         4'd9:    return {1'b0, 2'b10, 2'b00, 2'b01, 2'b00};
         4'd10:   return {1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic [1:0] imm_ref(input logic [6:0] op);
      case (op)
         7'b0100011: return 2'b01;
         7'b1100011: return 2'b10;
         7'b1101111: return 2'b11;
         default:    return 2'b00;
      endcase
   endfunction

   task automatic push(input logic rdy, input logic [3:0] st, input logic [6:0] stb);
      rdy_q.push_back(rdy);
      exp_q.push_back({st, stb});
   endtask

   // Reference expansion of one instruction; fs/ms = not-ready cycles in
   // FETCH and in MEMREAD/MEMWRITE. Non-memory states get random ready.
   task automatic push_instr(input logic [6:0] op, input logic z, input int fs, input int ms);
      for (int i = 0; i < fs; i++) push(1'b0, 4'd0, 7'b1000000);
      push(1'b1, 4'd0, 7'b1011000);
      case (op)
         7'b0000011, 7'b0100011: begin
            push(1'($urandom_range(0, 1)), 4'd1, 7'b0);
            push(1'($urandom_range(0, 1)), 4'd2, 7'b0);
            if (op == 7'b0000011) begin
               for (int i = 0; i < ms; i++) push(1'b0, 4'd3, 7'b1000000);
               push(1'b1, 4'd3, 7'b1000000);
               push(1'($urandom_range(0, 1)), 4'd4, 7'b0000110);
            end else begin
               for (int i = 0; i < ms; i++) push(1'b0, 4'd5, 7'b1000000);
               push(1'b1, 4'd5, 7'b1100010);
            end
         end
         7'b0110011, 7'b0010011: begin
            push(1'($urandom_range(0, 1)), 4'd1, 7'b0);
            push(1'($urandom_range(0, 1)), (op == 7'b0110011) ? 4'd6 : 4'd7, 7'b0);
            push(1'($urandom_range(0, 1)), 4'd8, 7'b0000110);
         end
         7'b1100011: begin
            push(1'($urandom_range(0, 1)), 4'd1, 7'b0);
            push(1'($urandom_range(0, 1)), 4'd9, {3'b000, z, 3'b010});
         end
         7'b1101111: begin
            push(1'($urandom_range(0, 1)), 4'd1, 7'b0);
            push(1'($urandom_range(0, 1)), 4'd10, 7'b0001000);
            push(1'($urandom_range(0, 1)), 4'd8, 7'b0000110);
         end
         default: push(1'($urandom_range(0, 1)), 4'd1, 7'b0000011);
      endcase
   endtask

   // Replay queued cycles; op/zero are held for the whole instruction.
   task automatic run_instr(input logic [6:0] op, input logic z, input int fs, input int ms);
      logic [10:0] e;
      op_i   = op;
      zero_i = z;
      push_instr(op, z, fs, ms);
      while (exp_q.size() > 0) begin
         e           = exp_q.pop_front();
         mem_ready_i = rdy_q.pop_front();
         @(negedge clk_i);
         check_val("cycle", 32'(observed()), 32'(e));
         check_val("mux", 32'({adr_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o}),
                   32'(mux_ref(e[10:7])));
         check_val("imm_src", 32'(imm_src_o), 32'(imm_ref(op)));
         @(posedge clk_i);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   logic [6:0] op_tab [0:7];

   initial begin
      op_tab[0] = 7'b0000011; op_tab[1] = 7'b0100011; op_tab[2] = 7'b0110011;
      op_tab[3] = 7'b0010011; op_tab[4] = 7'b1100011; op_tab[5] = 7'b1101111;
      op_tab[6] = 7'b1111111; op_tab[7] = 7'b0000000;

      rst_i = 1'b1; op_i = 7'b0110011; zero_i = 1'b0; mem_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_val("reset", 32'(observed()), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Directed cases
      run_instr(7'b0110011, 1'b0, 0, 0);   // r-type: 0,1,6,8
      run_instr(7'b0000011, 1'b0, 2, 3);   // lw with stalls
      run_instr(7'b0100011, 1'b0, 0, 0);   // sw
      run_instr(7'b1100011, 1'b1, 0, 0);   // beq taken
      run_instr(7'b1100011, 1'b0, 0, 0);   // beq not taken
      run_instr(7'b1101111, 1'b0, 0, 0);   // jal
      run_instr(7'b1111111, 1'b0, 0, 0);   // illegal
      run_instr(7'b0010011, 1'b0, 1, 0);   // i-type
      run_instr(7'b0100011, 1'b0, 1, 2);   // sw with stalls

      // Random mix
      for (int n = 0; n < 24; n++)
         run_instr(op_tab[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $urandom_range(0, 3));

      // Reset in MEMREAD: abort the lw, no strobes while reset is high
      op_i = 7'b0000011;
      push(1'b1, 4'd0, 7'b1011000);
      push(1'b1, 4'd1, 7'b0);
      push(1'b1, 4'd2, 7'b0);
      push(1'b0, 4'd3, 7'b1000000);
      while (exp_q.size() > 0) begin
         logic [10:0] e;
         e           = exp_q.pop_front();
         mem_ready_i = rdy_q.pop_front();
         @(negedge clk_i);
         check_val("pre_rst", 32'(observed()), 32'(e));
         @(posedge clk_i);
         #1;
      end
      rst_i = 1'b1; mem_ready_i = 1'b1;
      @(negedge clk_i);
      check_val("rst_in_memread", 32'(observed()), 32'({4'd3, 7'b0}));
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_val("rst_to_fetch", 32'(observed()), 32'({4'd0, 7'b0}));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      run_instr(7'b1101111, 1'b0, 0, 0);   // recovers cleanly after reset

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I datapath: one shared memory, one ALU, and architectural registers PC, OldPC, IR, Data and ALUOut.
- Sequences each instruction through Fetch/Decode/Execute/Writeback states.
- Drives all mux selects and write enables, and stalls on a memory ready handshake.
- Supports r-type, i-type ALU, lw, sw, beq and jal; any other opcode is flagged illegal and skipped.

Parameters:
- None.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- op_i  in  7  IR[6:0] opcode
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory access request
- mem_write_o  out  1  memory write strobe
- adr_src_o  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write_o  out  1  load IR and OldPC
- pc_write_o  out  1  load PC
- reg_write_o  out  1  register file write
- alu_src_a_o  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
- alu_src_b_o  out  2  ALU B select: 00=rs2, 01=imm, 10=constant 4
- alu_op_o  out  2  to alu_decoder: 00=add, 01=sub, 10=funct-decoded
- result_src_o  out  2  result select: 00=ALUOut, 01=Data, 10=ALU result
- imm_src_o  out  2  immediate format
- state_o  out  4  current state, for debug and verification
- instr_done_o  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_o  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset: state <= FETCH (0). While rst_i=1, every enable and strobe output is 0: mem_req, mem_write, ir_write, pc_write, reg_write, instr_done, illegal. Reset asserted mid-instruction aborts it with no further writes.
- Outputs are Moore, decoded from state, except: the handshake-gated strobes qualified by mem_ready_i, pc_write in BEQ (depends on zero_i), and imm_src_o (depends on op_i).
- Unlisted outputs are 0 in each state.
- State encoding and outputs:
  - FETCH=0: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. When mem_ready_i=1: ir_write=1, pc_write=1, advance to DECODE. Otherwise hold in FETCH with ir_write=pc_write=0.
  - DECODE=1: alu_src_a=01, alu_src_b=01, alu_op=00 (computes branch target). Next state by op_i:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other: illegal_o=1, instr_done_o=1, next FETCH
  - MEMADR=2: alu_src_a=10, alu_src_b=01, alu_op=00. Next MEMREAD if op_i=0000011, else MEMWRITE.
  - MEMREAD=3: mem_req=1, adr_src=1, result_src=00. Hold until mem_ready_i, then MEMWB.
  - MEMWB=4: result_src=01, reg_write=1, instr_done=1. Next FETCH.
  - MEMWRITE=5: mem_req=1, adr_src=1, result_src=00. mem_write_o=mem_ready_i. When ready: instr_done=1, next FETCH.
  - EXECR=6: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
  - EXECI=7: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
  - ALUWB=8: result_src=00, reg_write=1, instr_done=1. Next FETCH.
  - BEQ=9: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write=zero_i. instr_done=1. Next FETCH.
  - JAL=10: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next ALUWB.
  - Encodings 11-15: unreachable. If entered, go to FETCH next cycle with all strobes 0.
- imm_src_o (combinational from op_i):
  - lw / i-type -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - other -> 00
- Latency with mem_ready_i held at 1:
  - lw 5 cycles
  - sw 4 cycles
  - r-type / i-type 4 cycles
  - beq 3 cycles
  - jal 4 cycles
  - illegal 2 cycles
- Each cycle of mem_ready_i=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. mem_req_o stays high and adr_src_o stays stable throughout the stall.
- mem_write_o, ir_write_o and pc_write_o never assert in a cycle where mem_ready_i=0, except pc_write in JAL and BEQ, which do not depend on memory.
- op_i is sampled from IR, which is stable after FETCH; the FSM does not re-register it.

Test Plan:
- Reset, then rst_i=0 with op_i=0110011 and mem_ready_i=1 -> state_o sequence 0,1,6,8,0. reg_write_o=1 only in state 8; instr_done_o pulses once.
- lw (0000011), mem_ready_i=0 for 2 cycles in FETCH and 3 cycles in MEMREAD -> state sequence 0,0,0,1,2,3,3,3,3,4,0. ir_write_o=1 only in the third FETCH cycle; mem_req_o=1 in all FETCH and MEMREAD cycles.
- sw (0100011), mem_ready_i=1 -> states 0,1,2,5,0. mem_write_o=1 exactly once (state 5); imm_src_o=01; reg_write_o never 1.
- beq (1100011): first with zero_i=1 -> pc_write_o=1 in state 9; then with zero_i=0 -> pc_write_o=0. Both take 3 cycles; imm_src_o=10.
- jal (1101111) -> states 0,1,10,8,0. In state 10: pc_write_o=1, alu_src_a_o=01, alu_src_b_o=10. reg_write_o=1 in state 8.
- op_i=1111111 -> illegal_o=1 for one cycle in state 1, then state 0, with no reg/mem/pc write. Separately, assert rst_i during state 3 -> next state 0 and all strobes 0 while rst_i=1.
